// File: rtl/seq_shifter_pkg.sv
// Shared opcodes, FSM states and opcode legality for the iterative shifter.
// Rotate opcodes are legal only when SEQ_SHIFTER_ROTATE_EN is defined.
package seq_shifter_pkg;

   localparam logic [3:0] OP_SLL = 4'b0000;
   localparam logic [3:0] OP_SLA = 4'b0001;
   localparam logic [3:0] OP_SRL = 4'b0010;
   localparam logic [3:0] OP_SRA = 4'b0011;
   localparam logic [3:0] OP_ROL = 4'b0100;
   localparam logic [3:0] OP_ROR = 4'b0101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
`ifdef SEQ_SHIFTER_ROTATE_EN
      return (op <= OP_ROR);
`else
      return (op <= OP_SRA);
`endif
   endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// One-position shift/rotate of a WIDTH-bit value plus the bit that leaves it.
// Rotate muxing exists only when SEQ_SHIFTER_ROTATE_EN is defined.
module shift_step
   import seq_shifter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] value,
   input  logic [3:0]       opcode,
   output logic [WIDTH-1:0] shifted,
   output logic             bit_out
);

   always_comb begin
      shifted = value;
      bit_out = 1'b0;
      case (opcode)
         OP_SLL, OP_SLA: begin
            shifted = {value[WIDTH-2:0], 1'b0};
            bit_out = value[WIDTH-1];
         end
         OP_SRL: begin
            shifted = {1'b0, value[WIDTH-1:1]};
            bit_out = value[0];
         end
         // MSB is replicated each step, so repeated steps keep the original sign
         OP_SRA: begin
            shifted = {value[WIDTH-1], value[WIDTH-1:1]};
            bit_out = value[0];
         end
`ifdef SEQ_SHIFTER_ROTATE_EN
         OP_ROL: begin
            shifted = {value[WIDTH-2:0], value[WIDTH-1]};
            bit_out = value[WIDTH-1];
         end
         OP_ROR: begin
            shifted = {value[0], value[WIDTH-1:1]};
            bit_out = value[0];
         end
`endif
         default: begin
            shifted = value;
            bit_out = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seq_shifter.sv
// Iterative WIDTH-bit shift/rotate unit, one bit position per clock, valid/ready on both sides.
// Optional rotates via SEQ_SHIFTER_ROTATE_EN.
module seq_shifter
   import seq_shifter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic [SHW-1:0]   amt,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             err
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] work;
   logic [SHW-1:0]   count;
   logic [3:0]       op;
   logic             carry_q, err_q;
   logic [WIDTH-1:0] step_val;
   logic             step_bit;
   logic             accept;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .value   (work),
      .opcode  (op),
      .shifted (step_val),
      .bit_out (step_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (count == '0) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = in_valid && in_ready;

   // Illegal opcodes load zero work/count so they leave SHIFT on the first cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         work    <= '0;
         count   <= '0;
         op      <= OP_SLL;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (accept) begin
         op      <= opcode;
         carry_q <= 1'b0;
         if (op_legal(opcode)) begin
            work  <= data_in;
            count <= amt;
            err_q <= 1'b0;
         end else begin
            work  <= '0;
            count <= '0;
            err_q <= 1'b1;
         end
      end else if (state == SHIFT && count != '0) begin
         work    <= step_val;
         carry_q <= step_bit;
         count   <= count - SHW'(1);
      end
   end

   assign result = work;
   assign carry  = carry_q;
   assign err    = err_q;

endmodule
